// File: rtl/onehot_arb_pkg.sv
// Shared constants, FSM state type and helpers for the one-hot round-robin arbiter.
// Build option ONEHOT_ARB_OVERRUN_EN (used by onehot_rr_arbiter) enables the overrun flags.
package onehot_arb_pkg;

    // Fixed by the downstream 8-to-3 one-hot encoder.
    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;

    typedef logic [NREQ-1:0]  req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE  = 1'b0;
    localparam arb_state_t ARB_GRANT = 1'b1;

    localparam req_vec_t SRC0_ONEHOT = {{(NREQ-1){1'b0}}, 1'b1};
    // Reset value of last: source 0 is searched first after reset.
    localparam req_idx_t LAST_RESET  = req_idx_t'(NREQ - 1);

    function automatic req_idx_t onehot_to_idx(input req_vec_t oh);
        req_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of pending searching upward from last+1.
module rr_pick
    import onehot_arb_pkg::*;
(
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  onehot,
    output logic             found
);

    req_idx_t idx;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = last;
        // Offset NREQ wraps back to last itself, so it is checked last.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = last + req_idx_t'(i);
            if (!found && pending[idx]) begin
                onehot = SRC0_ONEHOT << idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: captures request pulses, issues one-hot grants over valid/ready.
// Define ONEHOT_ARB_OVERRUN_EN to build the sticky per-source overrun flags.
module onehot_rr_arbiter
    import onehot_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    input  logic            grant_ready,
    output logic [NREQ-1:0] overrun,
    input  logic            overrun_clr
);

    arb_state_t state_q, state_d;
    req_vec_t   pending_q, pending_d;
    req_vec_t   grant_q, grant_d;
    logic       grant_valid_q, grant_valid_d;
    req_idx_t   last_q, last_d;

    req_vec_t   pick_onehot;
    logic       pick_found;
    logic       handshake;
    req_vec_t   clr_mask;

    assign handshake = grant_valid_q & grant_ready;
    assign clr_mask  = handshake ? grant_q : '0;

    // A request in the handshake cycle re-arms the bit being cleared.
    assign pending_d = (pending_q & ~clr_mask) | req;

    rr_pick u_rr_pick (
        .pending (pending_q),
        .last    (last_q),
        .onehot  (pick_onehot),
        .found   (pick_found)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        last_d        = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d       = pick_onehot;
                    grant_valid_d = 1'b1;
                    state_d       = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (handshake) begin
                    last_d        = onehot_to_idx(grant_q);
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    state_d       = ARB_IDLE;
                end
            end
            default: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                state_d       = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            pending_q     <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            last_q        <= LAST_RESET;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            last_q        <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;

`ifdef ONEHOT_ARB_OVERRUN_EN
    req_vec_t overrun_q, overrun_d, overrun_set;

    always_comb begin
        overrun_set = req & pending_q & ~clr_mask;
        overrun_d   = overrun_clr ? '0 : (overrun_q | overrun_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = overrun_clr;
    assign overrun            = '0;
`endif

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: per-cycle model compare plus directed literal checks.
module tb_onehot_rr_arbiter;

`ifdef ONEHOT_ARB_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_ready;
    logic [7:0] overrun;
    logic       overrun_clr;

    int vectors     = 0;
    int miscompares = 0;

    onehot_rr_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pending set of sources, index of last winner, current winner (-1 = none).
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_ovr  = 8'h00;
    int         m_last = 7;
    int         m_gidx = -1;

    function automatic int rr_first(input logic [7:0] p, input int last);
        for (int k = 1; k <= 8; k++) begin
            int j;
            j = (last + k) % 8;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [7:0] idx_vec(input int idx);
        logic [7:0] v;
        v = 8'h00;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] clr_vec(input int gidx, input logic rdy);
        return (gidx >= 0 && rdy) ? idx_vec(gidx) : 8'h00;
    endfunction

    function automatic int vec_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 8'h00;
            m_ovr  <= 8'h00;
            m_last <= 7;
            m_gidx <= -1;
        end else begin
            if (m_gidx < 0) begin
                if (m_pend != 8'h00) m_gidx <= rr_first(m_pend, m_last);
            end else if (grant_ready) begin
                m_last <= m_gidx;
                m_gidx <= -1;
            end
            m_pend <= (m_pend & ~clr_vec(m_gidx, grant_ready)) | req;
            if (OVR_EN) begin
                m_ovr <= overrun_clr ? 8'h00
                       : (m_ovr | (req & m_pend & ~clr_vec(m_gidx, grant_ready)));
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (grant !== idx_vec(m_gidx) || grant_valid !== (m_gidx >= 0) || overrun !== m_ovr) begin
            miscompares++;
            $display("FAIL model t=%0t: grant=%b valid=%b overrun=%b, required grant=%b valid=%b overrun=%b",
                     $time, grant, grant_valid, overrun, idx_vec(m_gidx), (m_gidx >= 0), m_ovr);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %b, required %b", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int order[$];
    int n5;
    logic prev_valid;

    initial begin
        rst_n       = 1'b0;
        req         = 8'h00;
        grant_ready = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_grant", grant, 8'h00);
        check("reset_valid", {7'b0, grant_valid}, 8'h00);
        check("reset_overrun", overrun, 8'h00);
        rst_n       = 1'b1;
        grant_ready = 1'b1;

        // Single pulse on source 2: valid two edges later, for exactly one cycle.
        @(negedge clk); req = 8'b0000_0100;
        @(negedge clk); req = 8'h00;
        check("t1_not_yet", {7'b0, grant_valid}, 8'h00);
        @(negedge clk);
        check("t1_grant", grant, 8'b0000_0100);
        check("t1_valid", {7'b0, grant_valid}, 8'h01);
        @(negedge clk);
        check("t1_drop", {7'b0, grant_valid}, 8'h00);

        // All sources at once after reset: strict order 0..7, never back-to-back.
        do_reset();
        @(negedge clk); req = 8'hFF;
        @(negedge clk); req = 8'h00;
        prev_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant_valid) order.push_back(vec_idx(grant));
            if (prev_valid && grant_valid) check("t2_gap", 8'h01, 8'h00);
            prev_valid = grant_valid;
        end
        check("t2_count", 8'(order.size()), 8'd8);
        for (int i = 0; i < 8 && i < order.size(); i++) begin
            check("t2_order", 8'(order[i]), 8'(i));
        end

        // Stalled grant to source 3 is frozen despite higher-priority req[0].
        grant_ready = 1'b0;
        @(negedge clk); req = 8'b0000_1000;
        @(negedge clk); req = 8'h00;
        @(negedge clk);
        check("t3_grant", grant, 8'b0000_1000);
        req = 8'b0000_0001;
        @(negedge clk); req = 8'h00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t3_frozen", grant, 8'b0000_1000);
        end
        grant_ready = 1'b1;
        @(negedge clk);
        check("t3_accepted", {7'b0, grant_valid}, 8'h00);
        @(negedge clk);
        check("t3_next", grant, 8'b0000_0001);
        @(negedge clk);

        // Second req[5] while pending: merged, flagged, one grant only.
        grant_ready = 1'b0;
        @(negedge clk); req = 8'b0010_0000;
        @(negedge clk); req = 8'h00;
        @(negedge clk); req = 8'b0010_0000;
        @(negedge clk); req = 8'h00;
        check("t4_grant", grant, 8'b0010_0000);
        check("t4_overrun", overrun, OVR_EN ? 8'b0010_0000 : 8'h00);
        grant_ready = 1'b1;
        @(negedge clk);
        check("t4_accepted", {7'b0, grant_valid}, 8'h00);
        n5 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (grant_valid && grant[5]) n5++;
        end
        check("t4_single_grant", 8'(n5), 8'd0);
        overrun_clr = 1'b1;
        @(negedge clk); overrun_clr = 1'b0;
        check("t4_clear", overrun, 8'h00);

        // req[2] in the handshake cycle of grant 2: re-granted, no overrun.
        grant_ready = 1'b0;
        @(negedge clk); req = 8'b0000_0100;
        @(negedge clk); req = 8'h00;
        @(negedge clk);
        check("t5_grant", grant, 8'b0000_0100);
        req         = 8'b0000_0100;
        grant_ready = 1'b1;
        @(negedge clk); req = 8'h00;
        check("t5_drop", {7'b0, grant_valid}, 8'h00);
        check("t5_no_overrun", overrun, 8'h00);
        @(negedge clk);
        check("t5_regrant", grant, 8'b0000_0100);
        @(negedge clk);

        // Asynchronous reset while a grant is valid and unaccepted.
        grant_ready = 1'b0;
        @(negedge clk); req = 8'b0000_0001;
        @(negedge clk); req = 8'h00;
        @(negedge clk);
        check("t6_grant", grant, 8'b0000_0001);
        req = 8'b0000_0001;
        @(negedge clk); req = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_grant", grant, 8'h00);
        check("t6_rst_valid", {7'b0, grant_valid}, 8'h00);
        check("t6_rst_overrun", overrun, 8'h00);
        @(negedge clk);
        rst_n       = 1'b1;
        grant_ready = 1'b1;
        @(negedge clk); req = 8'b0100_0000;
        @(negedge clk); req = 8'h00;
        @(negedge clk);
        check("t6_after", grant, 8'b0100_0000);
        @(negedge clk);
        check("t6_after_drop", {7'b0, grant_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
